rr_mux_arbiter_4: RTL and testbench

- Round-robin arbiter that shares the 4:1 single-bit mux datapath among four requesters.
- Each requester owns one mux input bit. The block decides which requester drives the mux and generates the 2-bit select.
- A fairness limit stops one requester from holding the mux indefinitely while others wait.
- Sits between requester logic and the shared mux_4_to_1 instance, which it instantiates internally.

---
 rtl/rr_mux_arbiter_4.sv | 191 +++++++++++++++++++
 tb/tb_rr_mux_arbiter_4.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter_4
//   Round-robin arbiter that shares one 4:1 single-bit mux among four
//   requesters. Each requester owns one mux input bit. The arbiter picks the
//   owner, drives the registered 2-bit mux select, and limits how long an owner
//   may keep the mux while someone else is waiting.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset
//   req    in   4  request lines, req[i] = requester i wants the mux
//   in     in   4  data bits, in[i] belongs to requester i
//   gnt    out  4  one-hot grant (registered), zero when idle
//   sel    out  2  mux select = index of the granted requester (registered)
//   busy   out  1  1 while a grant is active (registered)
//   out    out  1  in[sel] when busy, else 0
//
// Also holds mux_4_to_1, the shared datapath instantiated by the arbiter.
// -----------------------------------------------------------------------------

// Plain 4:1 single-bit mux shared by the requesters.
module mux_4_to_1 (
    input  logic [3:0] in,
    input  logic [1:0] sel,
    output logic       out
);

    // Select one data bit.
    always_comb begin
        case (sel)
            2'd0:    out = in[0];
            2'd1:    out = in[1];
            2'd2:    out = in[2];
            2'd3:    out = in[3];
            default: out = 1'b0;
        endcase
    end

endmodule

module rr_mux_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       out
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_MAX);

    state_t     state_r;
    state_t     state_s;
    logic [1:0] ptr_r;
    logic [1:0] ptr_s;
    logic [3:0] hold_cnt_r;
    logic [3:0] hold_cnt_s;
    logic [3:0] gnt_s;
    logic [1:0] sel_s;
    logic       busy_s;
    logic       mux_out_s;
    logic       owner_req_s;
    logic [3:0] others_s;
    logic [1:0] next_ptr_s;

    // First requester at or after position p, scanning upward with wrap.
    // Scanning the rotation backwards lets the earliest match win last.
    function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] r);
        logic [1:0] idx;
        logic [1:0] res;
        res = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Decode of the current owner's request and of the competing requests.
    always_comb begin
        owner_req_s = req[sel];
        others_s    = req & ~(4'b0001 << sel);
        next_ptr_s  = sel + 2'd1;
    end

    // Next-state, grant and pointer decisions.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt;
        sel_s      = sel;
        busy_s     = busy;
        case (state_r)
            ST_IDLE: begin
                // First grant from idle does not move the pointer.
                if (req != 4'b0000) begin
                    sel_s      = pick(ptr_r, req);
                    gnt_s      = 4'b0001 << pick(ptr_r, req);
                    busy_s     = 1'b1;
                    hold_cnt_s = 4'd1;
                    state_s    = ST_GRANT;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s) begin
                    // Release: hand over at the same edge if anyone waits.
                    ptr_s = next_ptr_s;
                    if (req != 4'b0000) begin
                        sel_s      = pick(next_ptr_s, req);
                        gnt_s      = 4'b0001 << pick(next_ptr_s, req);
                        hold_cnt_s = 4'd1;
                    end else begin
                        gnt_s      = 4'b0000;
                        busy_s     = 1'b0;
                        hold_cnt_s = 4'd0;
                        state_s    = ST_IDLE;
                    end
                end else if (hold_cnt_r < HOLD_LIMIT) begin
                    hold_cnt_s = hold_cnt_r + 4'd1;
                end else if (others_s != 4'b0000) begin
                    // Preempt: the owner sits last in the new rotation, so a
                    // waiting requester is always picked ahead of it.
                    ptr_s      = next_ptr_s;
                    sel_s      = pick(next_ptr_s, req);
                    gnt_s      = 4'b0001 << pick(next_ptr_s, req);
                    hold_cnt_s = 4'd1;
                end else begin
                    // Sole requester: keep the grant, counter stays saturated.
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                gnt_s      = 4'b0000;
                busy_s     = 1'b0;
                hold_cnt_s = 4'd0;
            end
        endcase
    end

    // State, pointer and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 2'd0;
            hold_cnt_r <= 4'd0;
            gnt        <= 4'b0000;
            sel        <= 2'd0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            gnt        <= gnt_s;
            sel        <= sel_s;
            busy       <= busy_s;
        end
    end

    mux_4_to_1 u_mux (
        .in  (in),
        .sel (sel),
        .out (mux_out_s)
    );

    // Gate the shared mux output so an idle arbiter drives 0.
    always_comb begin
        if (busy) begin
            out = mux_out_s;
        end else begin
            out = 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter_4
//   Self-checking bench for rr_mux_arbiter_4 (HOLD_MAX = 4). A behavioural
//   model tracks owner / pointer / hold time as integers; directed scenarios
//   are followed by randomized requests, data and occasional resets.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter_4;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       out;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner = -1 when idle.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_sel   = 0;

    rr_mux_arbiter_4 #(.HOLD_MAX(HM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .in    (in),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int pickm(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the sampled inputs.
    task automatic model_edge();
        int others;
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner = pickm(m_ptr, req); m_sel = m_owner; m_hold = 1;
            end
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            if (req != 4'b0000) begin
                m_owner = pickm(m_ptr, req); m_sel = m_owner; m_hold = 1;
            end else begin
                m_owner = -1; m_hold = 0;
            end
        end else if (m_hold < HM) begin
            m_hold++;
        end else begin
            others = 0;
            for (int j = 0; j < 4; j++) if (j != m_owner && req[j]) others++;
            if (others > 0) begin
                m_ptr = (m_owner + 1) % 4;
                m_owner = pickm(m_ptr, req); m_sel = m_owner; m_hold = 1;
            end
        end
    endtask

    // Apply inputs, clock once, update the model, check all outputs.
    task automatic step(input logic r_n, input logic [3:0] rq, input logic [3:0] d);
        logic [3:0] e_gnt;
        logic       e_busy;
        logic       e_out;
        rst_n = r_n; req = rq; in = d;
        @(posedge clk);
        model_edge();
        #1;
        e_busy = (m_owner >= 0);
        e_gnt  = e_busy ? (4'b0001 << m_owner) : 4'b0000;
        e_out  = e_busy ? d[m_sel] : 1'b0;
        chk("gnt",  gnt, e_gnt);
        chk("sel",  {2'b00, sel}, 4'(m_sel));
        chk("busy", {3'b000, busy}, {3'b000, e_busy});
        chk("out",  {3'b000, out}, {3'b000, e_out});
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b1111; in = 4'b0000;

        // Reset with all requesting.
        step(1'b0, 4'b1111, 4'b1010);
        step(1'b0, 4'b1111, 4'b1010);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", {3'b000, busy}, 4'b0000);

        // Fairness rotation: 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001.
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 4'b1111, 4'($urandom_range(0, 15)));
            chk("fair_gnt", gnt, 4'b0001 << ((i / 4) % 4));
            chk("fair_sel", {2'b00, sel}, 4'((i / 4) % 4));
        end

        // Single requester 2 held, then released.
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 4'b0100, 4'b0100);
            chk("single_gnt", gnt, 4'b0100);
            chk("single_out", {3'b000, out}, 4'b0001);
        end
        step(1'b1, 4'b0000, 4'b0100);
        chk("drop_gnt", gnt, 4'b0000);
        chk("drop_sel", {2'b00, sel}, 4'd2);

        // Back-to-back handover from owner 3 to requester 1.
        step(1'b1, 4'b1000, 4'b0000);
        chk("own3_gnt", gnt, 4'b1000);
        step(1'b1, 4'b0010, 4'b0010);
        chk("b2b_gnt", gnt, 4'b0010);
        chk("b2b_busy", {3'b000, busy}, 4'b0001);

        // Mid-grant reset at owner 2, then pick from pointer 0.
        step(1'b1, 4'b0100, 4'b0000);
        step(1'b1, 4'b0100, 4'b0000);
        step(1'b1, 4'b0100, 4'b0000);
        chk("pre_rst_gnt", gnt, 4'b0100);
        step(1'b0, 4'b0100, 4'b0000);
        chk("midrst_gnt", gnt, 4'b0000);
        step(1'b1, 4'b1100, 4'b0000);
        chk("post_rst_gnt", gnt, 4'b0100);

        // Late contender against a saturated sole owner 0.
        for (int i = 0; i < 10; i++) step(1'b1, 4'b0001, 4'b0001);
        chk("sole_gnt", gnt, 4'b0001);
        step(1'b1, 4'b0101, 4'b0100);
        chk("late_gnt", gnt, 4'b0100);
        chk("late_sel", {2'b00, sel}, 4'd2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
